// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the asynchronous-SRAM controller: FSM state encoding,
// default strobe length and SRAM geometry.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WSETUP = 3'd2,
    WPULSE = 3'd3,
    WHOLD  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int WAIT_CYCLES_DEF = 2;
  localparam int SRAM_AW         = 20;
  localparam int REG_W           = 32;

endpackage

// File: rtl/sram_read_buf.sv
// One-entry last-read buffer: remembers the most recent SRAM read so a repeat
// read of the same word can be answered without touching the SRAM.
module sram_read_buf
  import sram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               fill,
  input  logic [SRAM_AW-1:0] fill_addr,
  input  logic [REG_W-1:0]   fill_data,
  input  logic               inval,
  input  logic               lookup,
  input  logic [SRAM_AW-1:0] lookup_addr,
  output logic               hit,
  output logic [REG_W-1:0]   data
);

  logic               valid;
  logic [SRAM_AW-1:0] tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (inval) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag  <= fill_addr;
      data <= fill_data;
    end
  end

  assign hit = lookup && valid && (tag == lookup_addr);

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage responder for an external 32-bit asynchronous SRAM; stalls the
// pipeline until each access completes. Optional last-read bypass: SRAM_LAST_READ_BYPASS_EN.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_req_o,
  inout  wire  [31:0] sram_data_io,
  output logic [19:0] sram_addr_o,
  output logic [3:0]  sram_be_n_o,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o
);

  state_t             state, next;
  logic [3:0]         cnt;
  logic [SRAM_AW-1:0] addr;
  logic [3:0]         sel;
  logic [REG_W-1:0]   wdata, rdata, buf_data;
  logic               accept, last, hit, drive;
  logic               unused_addr;

  assign unused_addr = ^{addr_i[31:22], addr_i[1:0]};
  assign last        = (cnt == 4'd1);
  assign accept      = (state == IDLE) && ce_i && !hit;

`ifdef SRAM_LAST_READ_BYPASS_EN
  sram_read_buf u_read_buf (
    .clk         (clk),
    .rst         (rst),
    .fill        ((state == READ) && last),
    .fill_addr   (addr),
    .fill_data   (sram_data_io),
    .inval       ((state == IDLE) && ce_i && we_i),
    .lookup      ((state == IDLE) && ce_i && !we_i),
    .lookup_addr (addr_i[21:2]),
    .hit         (hit),
    .data        (buf_data)
  );
`else
  assign hit      = 1'b0;
  assign buf_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // Once an SRAM cycle starts it runs to completion regardless of ce_i,
  // so a flush can never leave a half-written word behind.
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = we_i ? WSETUP : READ;
      READ:    if (last) next = DONE;
      WSETUP:  next = WPULSE;
      WPULSE:  if (last) next = WHOLD;
      WHOLD:   next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    sram_ce_n_o = 1'b1;
    sram_oe_n_o = 1'b1;
    sram_we_n_o = 1'b1;
    sram_be_n_o = 4'hF;
    drive       = 1'b0;
    stall_req_o = 1'b0;
    case (state)
      IDLE: stall_req_o = ce_i && !hit;
      READ: begin
        sram_ce_n_o = 1'b0;
        sram_oe_n_o = 1'b0;
        sram_be_n_o = ~sel;
        stall_req_o = 1'b1;
      end
      WSETUP, WHOLD: begin
        sram_ce_n_o = 1'b0;
        sram_be_n_o = ~sel;
        drive       = 1'b1;
        stall_req_o = 1'b1;
      end
      WPULSE: begin
        sram_ce_n_o = 1'b0;
        sram_we_n_o = 1'b0;
        sram_be_n_o = ~sel;
        drive       = 1'b1;
        stall_req_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      addr  <= '0;
      sel   <= '0;
      rdata <= '0;
    end else begin
      if (accept) begin
        cnt  <= 4'(WAIT_CYCLES);
        addr <= addr_i[21:2];
        sel  <= sel_i;
      end else if (state == READ || state == WPULSE) begin
        cnt <= cnt - 4'd1;
      end
      // A bypass hit also refreshes the read register so data_o keeps it.
      if (state == READ && last) begin
        rdata <= sram_data_io;
      end else if (hit) begin
        rdata <= buf_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wdata <= data_i;
    end
  end

  assign sram_data_io = drive ? wdata : 'z;
  assign sram_addr_o  = addr;
  assign data_o       = hit ? buf_data : rdata;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural async-SRAM model and a
// scoreboard of expected stall lengths and read words.
module tb_sram_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        stall_req_o;
  wire  [31:0] sram_bus;
  logic [19:0] sram_addr_o;
  logic [3:0]  sram_be_n_o;
  logic        sram_ce_n_o, sram_oe_n_o, sram_we_n_o;

  logic        load = 1'b1;
  logic [31:0] mem [256];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          sb_stall [$];
  logic [31:0] sb_data [$];

  sram_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .sel_i        (sel_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .stall_req_o  (stall_req_o),
    .sram_data_io (sram_bus),
    .sram_addr_o  (sram_addr_o),
    .sram_be_n_o  (sram_be_n_o),
    .sram_ce_n_o  (sram_ce_n_o),
    .sram_oe_n_o  (sram_oe_n_o),
    .sram_we_n_o  (sram_we_n_o)
  );

  always #5 clk = ~clk;

  // Idle bus floats high, so "not driven" reads as all ones.
  pullup (sram_bus);

  function automatic logic [31:0] init_word(input int i);
    case (i)
      8'h41:   return 32'hDEADBEEF;
      8'h02:   return 32'h11223344;
      default: return 32'hC0DE0000 | 32'(i);
    endcase
  endfunction

  assign sram_bus = (!sram_ce_n_o && !sram_oe_n_o && sram_we_n_o) ? mem[sram_addr_o[7:0]] : 32'hz;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (!sram_ce_n_o && !sram_we_n_o) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n_o[b]) mem[sram_addr_o[7:0]][b*8 +: 8] <= sram_bus[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int exp_stall, input logic [31:0] exp_rd,
                        input logic flush);
    int stall_n, ce_cnt, oe_cnt, we_cnt, drv_cnt, bus_bad, guard, exp_ce;
    logic [3:0]  be_seen;
    logic [19:0] addr_seen;
    stall_n = 0; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; drv_cnt = 0; bus_bad = 0; guard = 0;
    be_seen = 4'hF; addr_seen = '0;
    ce_i = 1'b1; we_i = w; addr_i = a; sel_i = s; data_i = d;
    sb_stall.push_back(exp_stall);
    if (!w) sb_data.push_back(exp_rd);
    @(negedge clk);
    while (stall_req_o === 1'b1 && guard < 50) begin
      stall_n++;
      if (!sram_ce_n_o) begin
        ce_cnt++;
        be_seen   = sram_be_n_o;
        addr_seen = sram_addr_o;
      end
      if (!sram_oe_n_o) oe_cnt++;
      if (!sram_we_n_o) we_cnt++;
      if (sram_oe_n_o && sram_bus !== 32'hFFFFFFFF) begin
        drv_cnt++;
        if (sram_bus !== d) bus_bad++;
      end
      @(posedge clk); #1;
      if (flush) ce_i = 1'b0;
      @(negedge clk);
      guard++;
    end
    chk({tag, "_no_timeout"}, 32'(guard < 50), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(sb_stall.pop_front()));
    chk({tag, "_strobes_idle_at_end"}, {29'd0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o}, 32'd7);
    exp_ce = (exp_stall == 0) ? 0 : (w ? W + 2 : W);
    chk({tag, "_ce_cycles"}, 32'(ce_cnt), 32'(exp_ce));
    if (!w) begin
      chk({tag, "_data_o"}, data_o, sb_data.pop_front());
      chk({tag, "_oe_cycles"}, 32'(oe_cnt), 32'(exp_ce));
    end else begin
      chk({tag, "_we_cycles"}, 32'(we_cnt), 32'(W));
      chk({tag, "_bus_driven_cycles"}, 32'(drv_cnt), 32'(W + 2));
      chk({tag, "_bus_value_bad"}, 32'(bus_bad), 32'd0);
    end
    if (ce_cnt > 0) begin
      chk({tag, "_be_n"}, {28'd0, be_seen}, {28'd0, ~s});
      chk({tag, "_sram_addr"}, {12'd0, addr_seen}, {12'd0, a[21:2]});
    end
    @(posedge clk); #1;
    ce_i = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_strobes", {29'd0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o}, 32'd7);
    chk("rst_be_n", {28'd0, sram_be_n_o}, 32'hF);
    chk("rst_addr", {12'd0, sram_addr_o}, 32'd0);
    chk("rst_bus_hiz", sram_bus, 32'hFFFFFFFF);
    chk("rst_data_o", data_o, 32'd0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk); #1;
    load = 1'b0;
    rst  = 1'b0;

    // Full-word read of word 0x41
    access("read", 1'b0, 32'h0000_0104, 4'hF, 32'd0, W + 1, 32'hDEADBEEF, 1'b0);

    // Byte-lane write into word 2, lane 1 only
    access("bytewr", 1'b1, 32'h0000_0008, 4'b0010, 32'h0000_AB00, W + 3, 32'd0, 1'b0);
    chk("bytewr_word2", mem[2], 32'h1122AB44);
    chk("bytewr_word3", mem[3], init_word(3));

    // Flush: ce_i drops after the request cycle, the read still completes
    access("flush", 1'b0, 32'h0000_000C, 4'hF, 32'd0, W + 1, init_word(3), 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_idle_strobes", {28'd0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, stall_req_o}, 32'hE);
      chk("flush_data_hold", data_o, init_word(3));
    end
    @(posedge clk); #1;

    // Back-to-back write then read of the same word
    access("b2b_wr", 1'b1, 32'h0000_0010, 4'hF, 32'h12345678, W + 3, 32'd0, 1'b0);
    access("b2b_rd", 1'b0, 32'h0000_0010, 4'hF, 32'd0, W + 1, 32'h12345678, 1'b0);
    chk("b2b_mem", mem[4], 32'h12345678);

`ifdef SRAM_LAST_READ_BYPASS_EN
    access("byp_rd1", 1'b0, 32'h0000_0020, 4'hF, 32'd0, W + 1, init_word(8), 1'b0);
    access("byp_hit", 1'b0, 32'h0000_0020, 4'hF, 32'd0, 0, init_word(8), 1'b0);
    access("byp_wr", 1'b1, 32'h0000_0020, 4'hF, 32'h0BADCAFE, W + 3, 32'd0, 1'b0);
    access("byp_rd2", 1'b0, 32'h0000_0020, 4'hF, 32'd0, W + 1, 32'h0BADCAFE, 1'b0);
`endif

    // Asynchronous reset in the middle of the write pulse
    ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0100; sel_i = 4'hF; data_i = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rstpulse_we_low", {31'd0, sram_we_n_o}, 32'd0);
    #2;
    rst  = 1'b1;
    ce_i = 1'b0;
    #1;
    chk("rstpulse_strobes", {29'd0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o}, 32'd7);
    chk("rstpulse_be_n", {28'd0, sram_be_n_o}, 32'hF);
    chk("rstpulse_bus_hiz", sram_bus, 32'hFFFFFFFF);
    chk("rstpulse_stall", {31'd0, stall_req_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {28'd0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, stall_req_o}, 32'hE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
